// File: rtl/i2c_write_scheduler.sv
// Shares one byte-level I2C master between NREQ requesters; each grant performs one 16-bit
// register write with NACK retry. Define I2C_SCHED_RR_EN for round-robin arbitration.
module i2c_write_scheduler #(
    parameter int unsigned NREQ      = 2,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned RETRY_GAP = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*7-1:0]    addr_i,
    input  logic [NREQ*8-1:0]    reg_i,
    input  logic [NREQ*16-1:0]   data_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic [NREQ-1:0]      done_o,
    output logic [NREQ-1:0]      err_o,
    output logic                 busy_o,
    output logic                 m_valid_o,
    output logic                 m_start_o,
    output logic                 m_stop_o,
    output logic [7:0]           m_byte_o,
    input  logic                 m_ready_i,
    input  logic                 m_done_i,
    input  logic                 m_nack_i
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSend,
        StWait,
        StGap,
        StFinish
    } state_t;

    state_t         r_state;
    logic [IW-1:0]  r_sel;
    logic [6:0]     r_addr;
    logic [7:0]     r_reg;
    logic [15:0]    r_data;
    logic [1:0]     r_idx;
    logic [RW-1:0]  r_retry;
    logic [7:0]     r_gap;
`ifdef I2C_SCHED_RR_EN
    logic [IW-1:0]  r_ptr;
`endif

    logic           w_any;
    logic [IW-1:0]  w_win;
    logic [6:0]     w_ld_addr;
    logic [7:0]     w_ld_reg;
    logic [15:0]    w_ld_data;
    logic [1:0]     w_nidx;

    function automatic logic [7:0] f_byte(input logic [1:0] idx, input logic [6:0] a,
                                          input logic [7:0] r, input logic [15:0] d);
        logic [7:0] b;
        case (idx)
            2'd0:    b = {a, 1'b0};
            2'd1:    b = r;
            2'd2:    b = d[15:8];
            default: b = d[7:0];
        endcase
        return b;
    endfunction

    always_comb begin
        int unsigned c;
        w_any = 1'b0;
        w_win = '0;
        c     = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
`ifdef I2C_SCHED_RR_EN
            c = (32'(r_ptr) + 1 + i) % NREQ;
`else
            c = i;
`endif
            if (!w_any && req_i[c]) begin
                w_any = 1'b1;
                w_win = IW'(c);
            end
        end
    end

    assign w_ld_addr = addr_i[7*32'(r_sel) +: 7];
    assign w_ld_reg  = reg_i[8*32'(r_sel) +: 8];
    assign w_ld_data = data_i[16*32'(r_sel) +: 16];
    assign w_nidx    = r_idx + 2'd1;
    assign busy_o    = (r_state != StIdle);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= StIdle;
            r_sel     <= '0;
            r_addr    <= '0;
            r_reg     <= '0;
            r_data    <= '0;
            r_idx     <= '0;
            r_retry   <= '0;
            r_gap     <= '0;
`ifdef I2C_SCHED_RR_EN
            r_ptr     <= '0;
`endif
            gnt_o     <= '0;
            done_o    <= '0;
            err_o     <= '0;
            m_valid_o <= 1'b0;
            m_start_o <= 1'b0;
            m_stop_o  <= 1'b0;
            m_byte_o  <= 8'h00;
        end else begin
            done_o <= '0;
            err_o  <= '0;
            unique case (r_state)
                StIdle: begin
                    // No grant during the error-pulse cycle so the requester can drop req_i.
                    if (w_any && (err_o == '0)) begin
                        gnt_o   <= NREQ'(1) << w_win;
                        r_sel   <= w_win;
`ifdef I2C_SCHED_RR_EN
                        r_ptr   <= w_win;
`endif
                        r_state <= StLoad;
                    end
                end
                StLoad: begin
                    r_addr    <= w_ld_addr;
                    r_reg     <= w_ld_reg;
                    r_data    <= w_ld_data;
                    r_idx     <= 2'd0;
                    r_retry   <= '0;
                    m_valid_o <= 1'b1;
                    m_start_o <= 1'b1;
                    m_stop_o  <= 1'b0;
                    m_byte_o  <= {w_ld_addr, 1'b0};
                    r_state   <= StSend;
                end
                StSend: begin
                    if (m_ready_i) begin
                        m_valid_o <= 1'b0;
                        m_start_o <= 1'b0;
                        m_stop_o  <= 1'b0;
                        r_state   <= StWait;
                    end
                end
                StWait: begin
                    if (m_done_i) begin
                        if (!m_nack_i) begin
                            if (r_idx != 2'd3) begin
                                r_idx     <= w_nidx;
                                m_valid_o <= 1'b1;
                                m_start_o <= 1'b0;
                                m_stop_o  <= (w_nidx == 2'd3);
                                m_byte_o  <= f_byte(w_nidx, r_addr, r_reg, r_data);
                                r_state   <= StSend;
                            end else begin
                                done_o  <= gnt_o;
                                r_state <= StFinish;
                            end
                        end else if (r_retry < RW'(MAX_RETRY)) begin
                            r_retry <= r_retry + 1'b1;
                            r_gap   <= 8'(RETRY_GAP);
                            r_state <= StGap;
                        end else begin
                            err_o   <= gnt_o;
                            gnt_o   <= '0;
                            r_retry <= '0;
                            r_state <= StIdle;
                        end
                    end
                end
                StGap: begin
                    // The last counted idle cycle launches the restart with START.
                    if (r_gap <= 8'd1) begin
                        r_gap     <= 8'd0;
                        r_idx     <= 2'd0;
                        m_valid_o <= 1'b1;
                        m_start_o <= 1'b1;
                        m_stop_o  <= 1'b0;
                        m_byte_o  <= {r_addr, 1'b0};
                        r_state   <= StSend;
                    end else begin
                        r_gap <= r_gap - 8'd1;
                    end
                end
                StFinish: begin
                    gnt_o   <= '0;
                    r_retry <= '0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule
